// File: rtl/tdm_demux_pkg.sv
// rtl/tdm_demux_pkg.sv - shared types and helpers for the TDM link (RX and TX sides)
// Contents: state_t (ST_IDLE/ST_RECV), clog2(), frame_bits()
package tdm_demux_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RECV = 1'b1
    } state_t;

    // Width helper: returns at least 1 so it can size any counter directly.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return (r == 0) ? 1 : r;
    endfunction

    function automatic int frame_bits(input int nch, input int w);
        return nch * w;
    endfunction

endpackage

// File: rtl/tdm_demux_if.sv
// rtl/tdm_demux_if.sv - serial input and demuxed output bundle of the TDM receiver
// master: drives din/din_valid/frame_start, observes outputs
// slave : receiver side, drives ch_data/frame_done/sync_err/busy/frame_cnt
interface tdm_demux_if #(
    parameter int NCH = 4,
    parameter int W   = 2
);
    logic               din;
    logic               din_valid;
    logic               frame_start;
    logic [NCH*W-1:0]   ch_data;
    logic               frame_done;
    logic               sync_err;
    logic               busy;
    logic [7:0]         frame_cnt;

    modport master (
        output din, din_valid, frame_start,
        input  ch_data, frame_done, sync_err, busy, frame_cnt
    );

    modport slave (
        input  din, din_valid, frame_start,
        output ch_data, frame_done, sync_err, busy, frame_cnt
    );
endinterface

// File: rtl/tdm_demux_sipo.sv
// rtl/tdm_demux_sipo.sv - N-bit serial-in/parallel-out staging register
// Ports: clk, rst (async high), clr, shift, din -> q
// shift&clr loads din as the first bit of a fresh frame; clr alone empties it.
module tdm_sipo #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         shift,
    input  logic         din,
    output logic [N-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (shift) begin
            q <= clr ? {{(N-1){1'b0}}, din} : {q[N-2:0], din};
        end else if (clr) begin
            q <= '0;
        end
    end

endmodule

// File: rtl/tdm_demux.sv
// rtl/tdm_demux.sv - TDM serial receiver: deserialize, steer slots, atomic commit
// Ports: CLOCK_50, RESET (async high), bus (tdm_demux_if.slave):
//   din/din_valid/frame_start in; ch_data, frame_done, sync_err, busy, frame_cnt out
module tdm_demux
    import tdm_demux_pkg::*;
#(
    parameter int NCH     = 4,
    parameter int W       = 2,
    parameter int TIMEOUT = 16
) (
    input  logic        CLOCK_50,
    input  logic        RESET,
    tdm_demux_if.slave  bus
);

    localparam int FRAME_BITS = frame_bits(NCH, W);
    localparam int BCW        = clog2(FRAME_BITS + 1);
    localparam int ICW        = clog2(TIMEOUT + 1);
    localparam logic [BCW-1:0] LAST_BIT  = BCW'(FRAME_BITS - 1);
    localparam logic [ICW-1:0] IDLE_LAST = ICW'(TIMEOUT - 1);
    localparam logic [ICW-1:0] IDLE_SAT  = ICW'(TIMEOUT);

    state_t                 state;
    logic [BCW-1:0]         bit_cnt;
    logic [ICW-1:0]         idle_cnt;
    logic                   commit_pend;
    logic [FRAME_BITS-1:0]  stage;
    logic [FRAME_BITS-1:0]  stage_ordered;
    logic [FRAME_BITS-1:0]  ch_data_r;
    logic                   frame_done_r;
    logic                   sync_err_r;
    logic                   busy_r;
    logic [7:0]             frame_cnt_r;
    logic                   sipo_shift;
    logic                   sipo_clr;
    logic                   timeout;

    assign timeout = (state == ST_RECV) && !bus.din_valid && (idle_cnt == IDLE_LAST);

    always_comb begin
        sipo_shift = 1'b0;
        sipo_clr   = 1'b0;
        if (bus.din_valid) begin
            if (state == ST_IDLE) begin
                sipo_shift = bus.frame_start;
                sipo_clr   = bus.frame_start;
            end else begin
                sipo_shift = 1'b1;
                sipo_clr   = bus.frame_start;
            end
        end else if (timeout) begin
            sipo_clr = 1'b1;
        end
    end

    tdm_sipo #(.N(FRAME_BITS)) u_sipo (
        .clk   (CLOCK_50),
        .rst   (RESET),
        .clr   (sipo_clr),
        .shift (sipo_shift),
        .din   (bus.din),
        .q     (stage)
    );

    // The first bit received ends up at the top of the shift register, so
    // channel 0 lives in the most significant slot and must be reversed.
    for (genvar c = 0; c < NCH; c++) begin : g_steer
        assign stage_ordered[c*W +: W] = stage[(NCH-1-c)*W +: W];
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state        <= ST_IDLE;
            bit_cnt      <= '0;
            idle_cnt     <= '0;
            commit_pend  <= 1'b0;
            ch_data_r    <= '0;
            frame_done_r <= 1'b0;
            sync_err_r   <= 1'b0;
            busy_r       <= 1'b0;
            frame_cnt_r  <= 8'd0;
        end else begin
            frame_done_r <= 1'b0;
            sync_err_r   <= 1'b0;
            commit_pend  <= 1'b0;

            // Commit reads the staging register the cycle after the last bit;
            // a back-to-back frame_start reloads it on this same edge.
            if (commit_pend) begin
                ch_data_r    <= stage_ordered;
                frame_done_r <= 1'b1;
                frame_cnt_r  <= frame_cnt_r + 8'd1;
            end

            case (state)
                ST_IDLE: begin
                    if (bus.din_valid && bus.frame_start) begin
                        state    <= ST_RECV;
                        busy_r   <= 1'b1;
                        bit_cnt  <= BCW'(1);
                        idle_cnt <= '0;
                    end
                end
                ST_RECV: begin
                    if (bus.din_valid) begin
                        idle_cnt <= '0;
                        if (bus.frame_start) begin
                            bit_cnt    <= BCW'(1);
                            sync_err_r <= 1'b1;
                        end else if (bit_cnt == LAST_BIT) begin
                            state       <= ST_IDLE;
                            busy_r      <= 1'b0;
                            bit_cnt     <= '0;
                            commit_pend <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + BCW'(1);
                        end
                    end else if (timeout) begin
                        state      <= ST_IDLE;
                        busy_r     <= 1'b0;
                        bit_cnt    <= '0;
                        idle_cnt   <= '0;
                        sync_err_r <= 1'b1;
                    end else if (idle_cnt != IDLE_SAT) begin
                        idle_cnt <= idle_cnt + ICW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.ch_data    = ch_data_r;
    assign bus.frame_done = frame_done_r;
    assign bus.sync_err   = sync_err_r;
    assign bus.busy       = busy_r;
    assign bus.frame_cnt  = frame_cnt_r;

endmodule

// File: tb/tb_tdm_demux.sv
// tb/tb_tdm_demux.sv - scoreboard bench for tdm_demux (NCH=4, W=2, TIMEOUT=16)
module tb_tdm_demux;

    logic clk;
    logic rst;
    int   cyc;
    int   n_cmp;
    int   n_bad;
    logic [7:0] model_cnt;

    typedef struct {
        logic [7:0] data;
        logic [7:0] cnt;
        int         cyc;
    } exp_t;

    exp_t fq[$];
    int   sq[$];

    tdm_demux_if #(.NCH(4), .W(2)) bus ();

    tdm_demux #(.NCH(4), .W(2), .TIMEOUT(16)) dut (
        .CLOCK_50 (clk),
        .RESET    (rst),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT pulses an event.
    initial begin
        exp_t e;
        int   s;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.frame_done && bus.sync_err)
                    check("done_err_overlap", 1, 0);
                if (bus.frame_done) begin
                    if (fq.size() == 0) begin
                        check("unexpected_frame_done", 1, 0);
                    end else begin
                        e = fq.pop_front();
                        check("commit_cycle", cyc, e.cyc);
                        check("ch_data", {24'd0, bus.ch_data}, {24'd0, e.data});
                        check("frame_cnt", {24'd0, bus.frame_cnt}, {24'd0, e.cnt});
                    end
                end
                if (bus.sync_err) begin
                    if (sq.size() == 0) begin
                        check("unexpected_sync_err", 1, 0);
                    end else begin
                        s = sq.pop_front();
                        check("sync_err_cycle", cyc, s);
                    end
                end
            end
        end
    end

    // One clock of stimulus; entered and left at a falling edge.
    task automatic drive(input logic v, input logic b, input logic fs);
        bus.din_valid   = v;
        bus.din         = b;
        bus.frame_start = fs;
        @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] seq, input int holes, input logic [7:0] exp_data);
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            if (i == 7) begin
                model_cnt = model_cnt + 8'd1;
                e.data = exp_data;
                e.cnt  = model_cnt;
                e.cyc  = cyc + 2;
                fq.push_back(e);
            end
            drive(1'b1, seq[7-i], i == 0);
            if (i < 7) begin
                for (int h = 0; h < holes; h++) begin
                    drive(1'b0, 1'b0, 1'b0);
                    check("busy_in_hole", {31'd0, bus.busy}, 1);
                end
            end
        end
    endtask

    task automatic send_partial(input int n);
        for (int i = 0; i < n; i++)
            drive(1'b1, 1'b1, i == 0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ch_data"}, {24'd0, bus.ch_data}, 0);
        check({tag, "_frame_done"}, {31'd0, bus.frame_done}, 0);
        check({tag, "_sync_err"}, {31'd0, bus.sync_err}, 0);
        check({tag, "_busy"}, {31'd0, bus.busy}, 0);
        check({tag, "_frame_cnt"}, {24'd0, bus.frame_cnt}, 0);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        model_cnt = 8'd0;
        rst = 1'b1;
        bus.din = 1'b0;
        bus.din_valid = 1'b0;
        bus.frame_start = 1'b0;
        repeat (2) @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0);

        // Stray valid bit in IDLE is ignored.
        drive(1'b1, 1'b1, 1'b0);
        check("idle_stray_busy", {31'd0, bus.busy}, 0);

        // Basic frame: 10|11|00|01 -> 8'h4E
        send_frame(8'b10110001, 0, 8'h4E);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        check("basic_busy_after", {31'd0, bus.busy}, 0);

        // Same frame with 3 holes between bits
        send_frame(8'b10110001, 3, 8'h4E);
        repeat (3) drive(1'b0, 1'b0, 1'b0);

        // Resync after 5 bits, then 01010101 -> 8'h55
        send_partial(5);
        check("resync_busy_mid", {31'd0, bus.busy}, 1);
        sq.push_back(cyc + 1);
        send_frame(8'b01010101, 0, 8'h55);
        repeat (3) drive(1'b0, 1'b0, 1'b0);

        // Timeout: 3 bits then 16 idle cycles
        send_partial(3);
        sq.push_back(cyc + 16);
        for (int h = 0; h < 16; h++) begin
            drive(1'b0, 1'b0, 1'b0);
            if (h == 14)
                check("timeout_busy_before", {31'd0, bus.busy}, 1);
        end
        check("timeout_busy_after", {31'd0, bus.busy}, 0);
        drive(1'b0, 1'b0, 1'b0);
        check("timeout_ch_data_kept", {24'd0, bus.ch_data}, 32'h55);
        check("timeout_frame_cnt", {24'd0, bus.frame_cnt}, 3);

        // Async reset mid-frame, between clock edges
        send_partial(4);
        bus.din_valid = 1'b0;
        #2 rst = 1'b1;
        #1 check_outputs_zero("async_reset");
        model_cnt = 8'd0;
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0);
        send_frame(8'b10110001, 0, 8'h4E);
        repeat (3) drive(1'b0, 1'b0, 1'b0);

        // 256 back-to-back frames of 8'hFF from a fresh reset
        rst = 1'b1;
        model_cnt = 8'd0;
        drive(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0);
        for (int f = 0; f < 256; f++)
            send_frame(8'hFF, 0, 8'hFF);
        repeat (4) drive(1'b0, 1'b0, 1'b0);
        check("wrap_frame_cnt", {24'd0, bus.frame_cnt}, 0);
        check("wrap_ch_data", {24'd0, bus.ch_data}, 32'hFF);

        check("pending_frame_done", fq.size(), 0);
        check("pending_sync_err", sq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
